// File: rtl/fib_arbiter.sv
// Round-robin arbiter/sequencer sharing one BCD Fibonacci engine between two requesters.
// Optional WAIT watchdog enabled by defining FIB_ARB_TIMEOUT_EN (parameter TMO, >= 2).
//
// state   | meaning
// IDLE    | no job; arbitrate when a request is pending and the engine is ready
// ISSUE   | pulse fib_start with the latched operand
// WAIT    | wait for fib_done (or the watchdog when enabled)
// DELIVER | pulse ack of the owner; res/err already valid
module fib_arbiter
`ifdef FIB_ARB_TIMEOUT_EN
#(
    parameter int unsigned TMO = 200
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  opa0,
    input  logic [7:0]  opa1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] res,
    output logic        err,
    output logic        busy,
    output logic        fib_start,
    output logic [7:0]  fib_opa,
    input  logic        fib_ready,
    input  logic        fib_done,
    input  logic [15:0] fib_q
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    localparam logic [15:0] OVF = 16'h9999;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic [7:0]  opa_q, opa_d;

    logic        win;
    logic [7:0]  win_opa;
    logic        bad_opa;

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO);
    logic [CW-1:0] tmr_q, tmr_d;
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        win     = (req0 & req1) ? ~last_q : req1;
        win_opa = win ? opa1 : opa0;
        bad_opa = (win_opa[7:4] > 4'd9) || (win_opa[3:0] > 4'd9);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        res_d   = res_q;
        err_d   = err_q;
        opa_d   = opa_q;
`ifdef FIB_ARB_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if ((req0 | req1) && fib_ready) begin
                    owner_d = win;
                    opa_d   = win_opa;
                    if (bad_opa) begin
                        res_d   = OVF;
                        err_d   = 1'b1;
                        state_d = DELIVER;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
`ifdef FIB_ARB_TIMEOUT_EN
                tmr_d   = CW'(TMO - 1);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (fib_done) begin
                    res_d   = fib_q;
                    err_d   = (fib_q == OVF);
                    state_d = DELIVER;
                end
`ifdef FIB_ARB_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    res_d   = OVF;
                    err_d   = 1'b1;
                    state_d = DELIVER;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            DELIVER: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= 16'h0000;
            err_q   <= 1'b0;
            opa_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            res_q   <= res_d;
            err_q   <= err_d;
            opa_q   <= opa_d;
        end
    end

`ifdef FIB_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`endif

    assign ack0      = (state_q == DELIVER) && !owner_q;
    assign ack1      = (state_q == DELIVER) &&  owner_q;
    assign fib_start = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign res       = res_q;
    assign err       = err_q;
    assign fib_opa   = opa_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed self-checking bench for fib_arbiter; the engine is played cycle by cycle
// from the stimulus sequence. The watchdog scenario runs only with FIB_ARB_TIMEOUT_EN.
module tb_fib_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  opa0 = 8'h00, opa1 = 8'h00;
    logic        ack0, ack1;
    logic [15:0] res;
    logic        err, busy, fib_start;
    logic [7:0]  fib_opa;
    logic        fib_ready = 1'b1;
    logic        fib_done = 1'b0;
    logic [15:0] fib_q = 16'h0000;

    int n_chk = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int ack1_cnt = 0;

    always #5 clk = ~clk;

`ifdef FIB_ARB_TIMEOUT_EN
    fib_arbiter #(.TMO(20)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .opa0(opa0), .opa1(opa1),
        .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
        .fib_start(fib_start), .fib_opa(fib_opa),
        .fib_ready(fib_ready), .fib_done(fib_done), .fib_q(fib_q)
    );
`else
    fib_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .opa0(opa0), .opa1(opa1),
        .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
        .fib_start(fib_start), .fib_opa(fib_opa),
        .fib_ready(fib_ready), .fib_done(fib_done), .fib_q(fib_q)
    );
`endif

    always @(negedge clk) begin
        if (fib_start) start_cnt++;
        if (ack1) ack1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 0);
        chk({tag, "_ack1"}, 32'(ack1), 0);
        chk({tag, "_res"}, 32'(res), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(fib_start), 0);
        chk({tag, "_opa"}, 32'(fib_opa), 0);
    endtask

    initial begin
        int s0;
        // ---- reset values
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // ---- single request, done two cycles after start
        req0 = 1'b1; opa0 = 8'h10;
        step();
        chk("s1_start", 32'(fib_start), 1);
        chk("s1_opa", 32'(fib_opa), 32'h10);
        chk("s1_busy", 32'(busy), 1);
        step();
        chk("s1_wait_start", 32'(fib_start), 0);
        step();
        fib_done = 1'b1; fib_q = 16'h0055;
        step();
        fib_done = 1'b0;
        chk("s1_ack0", 32'(ack0), 1);
        chk("s1_ack1", 32'(ack1), 0);
        chk("s1_res", 32'(res), 32'h0055);
        chk("s1_err", 32'(err), 0);
        req0 = 1'b0;
        step();
        chk("s1_ack0_off", 32'(ack0), 0);
        chk("s1_idle", 32'(busy), 0);
        chk("s1_res_hold", 32'(res), 32'h0055);
        chk("s1_starts", 32'(start_cnt), 1);
        chk("s1_no_ack1", 32'(ack1_cnt), 0);

        // ---- tie after reset: 0 first, then 1, then 0
        reset = 1'b1; step(); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; opa0 = 8'h05; opa1 = 8'h07;
        step();
        chk("t1_opa", 32'(fib_opa), 32'h05);
        step();
        fib_done = 1'b1; fib_q = 16'h0005;
        step();
        fib_done = 1'b0;
        chk("t1_ack0", 32'(ack0), 1);
        chk("t1_res", 32'(res), 32'h0005);
        step();
        chk("t1_idle", 32'(busy), 0);
        step();
        chk("t2_opa", 32'(fib_opa), 32'h07);
        chk("t2_start", 32'(fib_start), 1);
        step();
        fib_done = 1'b1; fib_q = 16'h0013;
        step();
        fib_done = 1'b0;
        chk("t2_ack1", 32'(ack1), 1);
        chk("t2_ack0", 32'(ack0), 0);
        chk("t2_res", 32'(res), 32'h0013);
        step();
        step();
        chk("t3_opa", 32'(fib_opa), 32'h05);
        step();
        fib_done = 1'b1; fib_q = 16'h0005;
        step();
        fib_done = 1'b0;
        chk("t3_ack0", 32'(ack0), 1);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // ---- invalid units digit from requester 1
        s0 = start_cnt;
        req1 = 1'b1; opa1 = 8'h1A;
        step();
        chk("inv_ack1", 32'(ack1), 1);
        chk("inv_res", 32'(res), 32'h9999);
        chk("inv_err", 32'(err), 1);
        req1 = 1'b0;
        step();
        chk("inv_idle", 32'(busy), 0);
        chk("inv_no_start", 32'(start_cnt), 32'(s0));
        chk("inv_err_hold", 32'(err), 1);

        // ---- engine overflow
        req0 = 1'b1; opa0 = 8'h25;
        step();
        step();
        fib_done = 1'b1; fib_q = 16'h9999;
        step();
        fib_done = 1'b0;
        chk("ovf_ack0", 32'(ack0), 1);
        chk("ovf_res", 32'(res), 32'h9999);
        chk("ovf_err", 32'(err), 1);
        req0 = 1'b0;
        step();

        // ---- stray done while idle is ignored
        fib_done = 1'b1; fib_q = 16'h1234;
        step();
        fib_done = 1'b0;
        step();
        chk("stray_busy", 32'(busy), 0);
        chk("stray_res", 32'(res), 32'h9999);

        // ---- engine not ready for 10 cycles
        fib_ready = 1'b0; req0 = 1'b1; opa0 = 8'h03;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) step();
        chk("rdy_no_start", 32'(start_cnt), 32'(s0));
        chk("rdy_busy", 32'(busy), 0);
        fib_ready = 1'b1;
        step();
        chk("rdy_start", 32'(fib_start), 1);
        step();
        fib_done = 1'b1; fib_q = 16'h0002;
        step();
        fib_done = 1'b0;
        chk("rdy_ack0", 32'(ack0), 1);
        chk("rdy_res", 32'(res), 32'h0002);
        chk("rdy_err", 32'(err), 0);
        req0 = 1'b0;
        step();

        // ---- async reset mid-WAIT, then a late done
        req1 = 1'b1; opa1 = 8'h09;
        step();
        step();
        step();
        chk("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        #1;
        reset = 1'b0;
        req1 = 1'b0;
        fib_done = 1'b1; fib_q = 16'h0034;
        step();
        fib_done = 1'b0;
        chk_reset_vals("late_done");
        step();
        chk("late_ack1", 32'(ack1), 0);

`ifdef FIB_ARB_TIMEOUT_EN
        // ---- watchdog with TMO=20: ack at t+22
        req0 = 1'b1; opa0 = 8'h12;
        step();
        chk("tmo_start", 32'(fib_start), 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("tmo_early_ack0", 32'(ack0), 0);
        end
        step();
        chk("tmo_ack0", 32'(ack0), 1);
        chk("tmo_res", 32'(res), 32'h9999);
        chk("tmo_err", 32'(err), 1);
        req0 = 1'b0;
        step();
        fib_done = 1'b1; fib_q = 16'h0144;
        step();
        fib_done = 1'b0;
        chk("tmo_late_res", 32'(res), 32'h9999);
        chk("tmo_late_busy", 32'(busy), 0);
`endif

        chk("ack1_total", 32'(ack1_cnt), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_arbiter.md
# fib_arbiter

Round-robin arbiter and sequencer that shares one BCD Fibonacci engine between two requesters. It accepts two-digit BCD operands from each requester, checks them, and issues jobs to the engine with a start pulse. It waits for the engine's done pulse, returns the four-digit BCD result on a shared result bus, and acknowledges the owning requester. It sits between the system-level request sources and the Fibonacci datapath, which it drives exclusively.

## Interface
- TMO, 200, watchdog limit in cycles spent in WAIT; only present with FIB_ARB_TIMEOUT_EN; must be ≥2.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- req0, req1  in  1  level request from requester 0/1; held until matching ack
- opa0, opa1  in  8  operand for requester 0/1, {tens, units} BCD; stable while req high
- ack0, ack1  out  1  one-cycle pulse: result for requester 0/1 is on res/err
- res  out  16  result, {d3,d2,d1,d0} BCD; holds last delivered value
- err  out  1  error flag accompanying res; holds with res
- busy  out  1  high in every state except IDLE
- fib_start  out  1  one-cycle start pulse to engine
- fib_opa  out  8  operand to engine; registered, stable from ISSUE until the next job
- fib_ready  in  1  engine idle
- fib_done  in  1  one-cycle pulse: fib_q valid
- fib_q  in  16  engine result, BCD; 16'h9999 means overflow

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER. Reset to IDLE.
- Reset values: ack0=ack1=0, res=0, err=0, busy=0, fib_start=0, fib_opa=0, owner=0, last=1 (requester 0 wins the first tie).
- IDLE: nothing happens unless (req0|req1) and fib_ready.
  - Winner: the sole requester; if both request, the one ≠ last.
  - Record owner; latch opa[owner] into fib_opa.
  - If either digit of the latched operand > 9, go to DELIVER with res=16'h9999, err=1, and no engine job.
  - Otherwise go to ISSUE.
- ISSUE: fib_start=1 for exactly this cycle, then WAIT.
- WAIT: fib_done=1 latches res=fib_q and err=(fib_q==16'h9999), then DELIVER. A fib_done seen in any other state is ignored.
- DELIVER: ack[owner]=1 for exactly this cycle; last←owner; go to IDLE.
- Request dropped mid-job: the job still completes and the ack still pulses.
- A requester that keeps req high after its ack is re-arbitrated normally; round-robin guarantees the other requester is served next.
- Operands of the non-owner are never sampled.

## Timing
- req sampled in IDLE at cycle t → fib_start high at t+1 → WAIT from t+2.
- fib_done at cycle d → res/err valid and ack high at d+1 → IDLE at d+2.
- Next grant is possible at d+2.
- Invalid-operand path: req at t → ack at t+1, IDLE at t+2.
- Back-to-back minimum: 4 cycles per job when the engine returns done one cycle after start.
- res/err change only on the cycle entering DELIVER.
- Asynchronous reset mid-job returns to IDLE at once and aborts the engine job from the arbiter's view. The engine's late fib_done is ignored because it arrives in IDLE.

## Configuration
- FIB_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and clears on entry.
  - If TMO cycles pass without fib_done, go to DELIVER with res=16'h9999, err=1.
  - A late fib_done is then ignored.
- FIB_ARB_TIMEOUT_EN undefined: no counter and no TMO parameter; WAIT waits indefinitely.

## Test plan
- Single request: req0=1, opa0=8'h10, engine returns 16'h0055 two cycles after start → fib_start once, ack0 at done+1, res=16'h0055, err=0, ack1 never.
- Tie after reset: req0=req1=1 held, opa0=8'h05, opa1=8'h07 → first ack0 with res=16'h0005, then ack1 with res=16'h0013, alternating thereafter.
- Invalid digit: req1=1, opa1=8'h1A → no fib_start, ack1 one cycle later, res=16'h9999, err=1.
- Engine overflow: opa0=8'h25, engine returns 16'h9999 → ack0, err=1.
- fib_ready low: req0=1 while fib_ready=0 for 10 cycles → no fib_start until the cycle after fib_ready rises.
- Reset mid-WAIT, then a stray fib_done: all outputs at reset values, no ack; with FIB_ARB_TIMEOUT_EN and TMO=20, withheld done → ack at cycle t+22 with res=16'h9999, err=1.
